shift_add_multiplier: RTL and testbench

Sequential unsigned shift-and-add multiplier: WIDTH×WIDTH operands, 2·WIDTH-bit product, one conditional add plus one right shift per cycle. Its datapath drives a WIDTH-bit ripple-carry add stage every cycle: the multiplicand and the upper accumulator half go in as operands, carry-in is 0, and the sum and carry-out are captured back into the accumulator. It sits between operand-producing control logic and result consumers, using a start/busy/done handshake.

---
 rtl/shift_add_multiplier.sv | 148 ++++++++++++++
 tb/tb_shift_add_multiplier.sv | 138 +++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier with a start/busy/done handshake.
// Optional macro MULT_ZERO_BYPASS_EN: zero operands skip iteration and finish early.
module shift_add_multiplier #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [PW-1:0]    product_q, product_d;
`ifdef MULT_ZERO_BYPASS_EN
  logic             byp_q, byp_d;
`endif

  logic [WIDTH-1:0] addend_c;
  logic [WIDTH:0]   carry_c;
  logic [WIDTH:0]   sum_c;

  // Ripple-carry add of acc_hi and the gated multiplicand; MSB of sum_c is the carry-out.
  always_comb begin
    addend_c   = mq_q[0] ? mcand_q : '0;
    carry_c    = '0;
    sum_c      = '0;
    carry_c[0] = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum_c[i]     = acc_hi_q[i] ^ addend_c[i] ^ carry_c[i];
      carry_c[i+1] = (acc_hi_q[i] & addend_c[i]) |
                     (acc_hi_q[i] & carry_c[i])  |
                     (addend_c[i] & carry_c[i]);
    end
    sum_c[WIDTH] = carry_c[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      mq_q      <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
`ifdef MULT_ZERO_BYPASS_EN
      byp_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      mq_q      <= mq_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
`ifdef MULT_ZERO_BYPASS_EN
      byp_q     <= byp_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    mq_d      = mq_q;
    count_d   = count_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
`ifdef MULT_ZERO_BYPASS_EN
    byp_d     = byp_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = a;
          acc_hi_d = '0;
          mq_d     = b;
          count_d  = '0;
          busy_d   = 1'b1;
          state_d  = S_CALC;
`ifdef MULT_ZERO_BYPASS_EN
          // Zero operand: product is known, spend a single busy cycle in DONE.
          if ((a == '0) || (b == '0)) begin
            product_d = '0;
            byp_d     = 1'b1;
            state_d   = S_DONE;
          end
`endif
        end
      end
      S_CALC: begin
        // {carry, acc_hi, mq} <= {sum, mq} >> 1
        acc_hi_d = sum_c[WIDTH:1];
        mq_d     = {sum_c[0], mq_q[WIDTH-1:1]};
        count_d  = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          product_d = {sum_c[WIDTH:1], sum_c[0], mq_q[WIDTH-1:1]};
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
`ifdef MULT_ZERO_BYPASS_EN
        if (byp_q) begin
          done_d = 1'b1;
          byp_d  = 1'b0;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (default build, WIDTH=4).
module tb_shift_add_multiplier;

  localparam int unsigned W = 4;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2*W-1:0] exp_prod;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  // One full transaction; noisy drives ignored start pulses at edges N+2, N+4, N+5.
  task automatic mult(input logic [W-1:0] ma, input logic [W-1:0] mb, input bit noisy);
    logic [2*W-1:0] expv;
    expv  = (2*W)'(ma) * (2*W)'(mb);
    a     = ma;
    b     = mb;
    start = 1'b1;
    step();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    check("busy_at_accept", 32'(busy), 32'd1);
    check("done_at_accept", 32'(done), 32'd0);
    check("product_held_at_accept", 32'(product), 32'(exp_prod));
    for (int k = 1; k <= int'(W); k++) begin
      if (noisy && (k == 2 || k == 4)) begin
        start = 1'b1;
        a     = W'(3);
        b     = W'(3);
      end
      step();
      start = 1'b0;
      check($sformatf("busy_iter%0d", k), 32'(busy), 32'd1);
      if (k < int'(W)) begin
        check($sformatf("done_iter%0d", k), 32'(done), 32'd0);
      end else begin
        check("done_pulse", 32'(done), 32'd1);
        check($sformatf("product_%0dx%0d", ma, mb), 32'(product), 32'(expv));
        exp_prod = expv;
      end
    end
    start = noisy;
    step();
    start = 1'b0;
    check("done_falls", 32'(done), 32'd0);
    check("busy_falls", 32'(busy), 32'd0);
    check("product_holds", 32'(product), 32'(exp_prod));
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    exp_prod = '0;
    step();
    step();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    rst_n = 1'b1;
    step();

    mult(W'(13), W'(11), 1'b0);
    step();
    check("product_hold_idle", 32'(product), 32'(exp_prod));
    mult(W'(15), W'(15), 1'b0);
    mult(W'(0), W'(9), 1'b0);
    mult(W'(7), W'(6), 1'b1);
    step();
    check("no_restart_busy", 32'(busy), 32'd0);
    check("no_extra_done", 32'(done), 32'd0);

    // Reset in the middle of a calculation discards the result.
    a     = W'(9);
    b     = W'(9);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    exp_prod = '0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("abort_no_done", 32'(done), 32'd0);
    end
    mult(W'(2), W'(3), 1'b0);

    // Back-to-back: the next start is presented on the first busy=0 cycle.
    mult(W'(5), W'(5), 1'b0);
    mult(W'(12), W'(3), 1'b0);
    for (int i = 0; i < 20; i++) begin
      mult(W'($urandom), W'($urandom), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
